// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes and opcode-class bit positions.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b10;

   // bit positions inside the one-hot opcode class vector
   localparam int CLS_R   = 0;
   localparam int CLS_I   = 1;
   localparam int CLS_BEQ = 2;
   localparam int CLS_JAL = 3;
   localparam int CLS_LW  = 4;
   localparam int CLS_SW  = 5;
   localparam int CLS_W   = 6;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: one-hot instruction class plus legal flag.
module opcode_classify
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 7
) (
   input  logic [OPCODE_W-1:0] op,
   output logic [CLS_W-1:0]    cls,
   output logic                legal
);

   // match the opcode against each supported encoding
   always_comb begin
      cls          = '0;
      cls[CLS_R]   = (op == OPCODE_W'(OP_R));
      cls[CLS_I]   = (op == OPCODE_W'(OP_I));
      cls[CLS_BEQ] = (op == OPCODE_W'(OP_BEQ));
      cls[CLS_JAL] = (op == OPCODE_W'(OP_JAL));
      cls[CLS_LW]  = (op == OPCODE_W'(OP_LW));
      cls[CLS_SW]  = (op == OPCODE_W'(OP_SW));
      legal        = |cls;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake, illegal-opcode detection and a retired-instruction counter.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W      = 7,
   parameter int MEM_HANDSHAKE = 1,
   parameter int CNT_W         = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                alu_src,
   output logic [1:0]          alu_op,
   output logic                branch,
   output logic                jump,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_2_reg,
   output logic                reg_write,
   output logic                illegal_instr,
   output logic                instr_done,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    retired_cnt
);

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [OPCODE_W-1:0] cls_src;
   logic [CLS_W-1:0]    cls;
   logic                op_legal;
   logic                mem_rdy;

   assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign state   = state_q;

   // DECODE classifies the live opcode; every later state sees only op_q
   assign cls_src = (state_q == S_DECODE) ? opcode : op_q;

   opcode_classify #(.OPCODE_W(OPCODE_W)) u_cls (
      .op    (cls_src),
      .cls   (cls),
      .legal (op_legal)
   );

   // state register, opcode latch and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         op_q        <= '0;
         retired_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

   // next-state and control outputs; everything held low during reset
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      alu_src       = 1'b0;
      alu_op        = ALU_ADD;
      branch        = 1'b0;
      jump          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_2_reg     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               if (mem_rdy) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end
            end
            S_DECODE: begin
               if (op_legal) begin
                  state_d = S_EXEC;
               end else begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            end
            S_EXEC: begin
               if (cls[CLS_R]) begin
                  alu_op  = ALU_RTYPE;
                  state_d = S_WB;
               end else if (cls[CLS_I]) begin
                  alu_src = 1'b1;
                  state_d = S_WB;
               end else if (cls[CLS_BEQ]) begin
                  alu_op     = ALU_SUB;
                  branch     = 1'b1;
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else if (cls[CLS_JAL]) begin
                  jump       = 1'b1;
                  pc_write   = 1'b1;
                  reg_write  = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                  alu_src = 1'b1;
                  state_d = S_MEM;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_MEM: begin
               if (cls[CLS_LW]) begin
                  mem_read = 1'b1;
                  if (mem_rdy) state_d = S_WB;
               end else if (cls[CLS_SW]) begin
                  mem_write = 1'b1;
                  if (mem_rdy) begin
                     instr_done = 1'b1;
                     state_d    = S_FETCH;
                  end
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_2_reg  = cls[CLS_LW];
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 7, opcode field width.
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = wait on mem_ready, 0 = mem_ready internally treated as 1.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  instruction opcode from instruction register.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  PC update enable.
- ir_write  out  1  instruction register load enable.
- alu_src  out  1  ALU operand B = immediate.
- alu_op  out  2  00 add, 01 sub, 10 R-type.
- branch  out  1  branch-equal evaluation.
- jump  out  1  jump target select.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_2_reg  out  1  writeback source = memory.
- reg_write  out  1  register file write enable.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode.
- instr_done  out  1  one-cycle pulse on instruction retire.
- state  out  3  current FSM state (debug).
- retired_cnt  out  CNT_W  retired-instruction count.

Function
REQ-005 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable, recover to FETCH.
REQ-006 FETCH SHALL drive mem_read=1; with mem_ready=1 drive ir_write=1, pc_write=1 and go to DECODE; else hold FETCH with ir_write=pc_write=0.
REQ-007 DECODE SHALL latch opcode into internal op_q; all later states decode op_q only, never opcode.
REQ-008 DECODE with unsupported opcode SHALL pulse illegal_instr, go to FETCH, and not pulse instr_done or increment retired_cnt.
REQ-009 Supported opcodes: R 0110011, I 0010011, BEQ 1100011, JAL 1101111, LW 0000011, SW 0100011.
REQ-010 DECODE with supported opcode SHALL go to EXEC; all control outputs 0 in DECODE.
REQ-011 EXEC: R drives alu_op=10, alu_src=0, then WB; I drives alu_op=00, alu_src=1, then WB.
REQ-012 EXEC: BEQ drives alu_op=01, branch=1, pc_write=1, instr_done=1, then FETCH.
REQ-013 EXEC: JAL drives jump=1, pc_write=1, reg_write=1, instr_done=1, then FETCH.
REQ-014 EXEC: LW/SW drive alu_op=00, alu_src=1, then MEM.
REQ-015 MEM: LW drives mem_read=1 and, on mem_ready, goes to WB; SW drives mem_write=1 and, on mem_ready, pulses instr_done and goes to FETCH; otherwise holds MEM.
REQ-016 WB SHALL drive reg_write=1, mem_2_reg=1 iff op_q=LW, instr_done=1, then FETCH.
REQ-017 Outputs not listed for a state SHALL be 0; outputs combinational from state, op_q and mem_ready only.
REQ-018 Latency with mem_ready held 1: BEQ/JAL 3, R/I/SW 4, LW 5 cycles; each wait cycle adds one.
REQ-019 retired_cnt SHALL increment by 1 in the cycle after each instr_done, wrapping modulo 2^CNT_W from all-ones to 0.

Reset
REQ-020 rst=1 SHALL force state=FETCH, op_q=0, retired_cnt=0 at next edge, overriding any transition.
REQ-021 While rst=1 every control output, illegal_instr and instr_done SHALL be 0, including mid-MEM wait.
REQ-022 First cycle after rst deassert SHALL be FETCH.

Structure
REQ-023 Opcode constants, ALUOp codes and state encoding SHALL reside in shared package ctrl_pkg.
REQ-024 Opcode-class decode SHALL be sub-module opcode_classify (combinational, op_q -> one-hot class + legal flag).

Verification
REQ-025 R 0110011, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=10),WB(reg_write=1), instr_done cycle 4, retired_cnt=1.
REQ-026 LW, mem_ready low 2 MEM cycles -> mem_read held 3 cycles in MEM, WB mem_2_reg=1, total 7 cycles.
REQ-027 Opcode 1111111 -> illegal_instr pulse in DECODE, back to FETCH, retired_cnt unchanged.
REQ-028 rst=1 during SW MEM wait -> mem_write=0 same cycle, state=0 next cycle, retired_cnt=0.
REQ-029 CNT_W=4, 16 BEQ instructions -> retired_cnt wraps 15 -> 0.
REQ-030 MEM_HANDSHAKE=0, mem_ready=0 constant -> SW completes in 4 cycles.
